// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive paths.
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_CLKS_PER_BIT_DEFAULT = 280;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_e;

endpackage : uart_pkg

// File: rtl/byte_fifo.sv
// Synchronous first-word fall-through FIFO. Occupancy is kept in its own
// counter so full and empty never depend on pointer comparisons.
module byte_fifo #(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    // Requests are gated so a push into a full FIFO or a pop from an empty one is ignored.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage array: written on an accepted push only.
    // NOTE: the data array has no reset; occupancy decides which entries are valid, and
    // leaving it out lets the array map onto plain RAM/flops without a reset tree.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; the counter tracks occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule : byte_fifo

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a byte FIFO feeds a frame serializer whose
// line output comes straight from a flop. Frames run back-to-back while the
// FIFO has data.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int  CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int  FIFO_DEPTH   = 4,
    localparam int CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [UART_DATA_BITS-1:0] data_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic                      tx_o,
    output logic                      busy_o,
    output logic [CNT_W-1:0]          count_o
);

    localparam int                  BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0]   BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]          BIT_LAST  = 3'(UART_DATA_BITS - 1);

    uart_tx_state_e              state_q;
    logic [BAUD_W-1:0]           baud_q;
    logic [2:0]                  bit_cnt_q;
    logic [UART_DATA_BITS-1:0]   shreg_q;
    logic                        tx_q;
    logic                        busy_q;

    logic                        baud_wrap;
    logic                        fifo_pop;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [UART_DATA_BITS-1:0]   fifo_rdata;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (valid_i),
        .pop    (fifo_pop),
        .wdata  (data_i),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (count_o)
    );

    // A bit boundary is the last cycle of the baud period; a new byte is taken from
    // the FIFO either from idle or at the very end of a stop bit.
    always_comb begin
        baud_wrap = (baud_q == BAUD_LAST);
        fifo_pop  = !fifo_empty &&
                    ((state_q == IDLE) || ((state_q == STOP) && baud_wrap));
    end

    // Frame sequencer: state, baud/bit counters, shift register and registered outputs.
    // NOTE: every register here uses <= so all branches see the pre-edge values; the
    // later baud_q clear on a pop intentionally overrides the free-running increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            if (state_q != IDLE) begin
                baud_q <= baud_wrap ? '0 : baud_q + 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (!fifo_empty) begin
                        shreg_q   <= fifo_rdata;
                        bit_cnt_q <= '0;
                        baud_q    <= '0;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= START;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                START: begin
                    if (baud_wrap) begin
                        tx_q    <= shreg_q[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (baud_wrap) begin
                        if (bit_cnt_q == BIT_LAST) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            shreg_q   <= shreg_q >> 1;
                            tx_q      <= shreg_q[1];
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (baud_wrap) begin
                        if (!fifo_empty) begin
                            shreg_q   <= fifo_rdata;
                            bit_cnt_q <= '0;
                            baud_q    <= '0;
                            tx_q      <= 1'b0;
                            state_q   <= START;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o = !fifo_full;
    assign tx_o    = tx_q;
    assign busy_o  = busy_q;

endmodule : uart_tx_buffered

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered. Pushed bytes go into a scoreboard
// queue; a line monitor decodes each frame from tx_o, compares every cycle of it
// against the expected waveform and pops the scoreboard at the end of the frame.
module tb_uart_tx_buffered;

    localparam int CPB   = 280;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk;
    logic       rst_ni;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;
    logic       tx_o;
    logic       busy_o;
    logic [2:0] count_o;

    int         cyc;
    int         n_tests;
    int         n_fail;
    logic [7:0] sb[$];
    int         start_cycs[$];
    int         frames_done;
    int         hs_cyc;

    // Monitor state
    bit         mon_active;
    int         mon_start;
    int         shape_errs;
    logic [7:0] rx_byte;
    logic [7:0] exp_byte;

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .tx_o    (tx_o),
        .busy_o  (busy_o),
        .count_o (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Line monitor: decode each frame and compare its waveform cycle by cycle.
    always @(negedge clk) begin
        int t;
        int bit_idx;
        logic exp_bit;
        if (!rst_ni) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx_o == 1'b0) begin
                mon_active = 1'b1;
                mon_start  = cyc;
                shape_errs = 0;
                rx_byte    = 8'h00;
                start_cycs.push_back(cyc);
                check("sb_has_entry", sb.size() != 0, 1);
                exp_byte = (sb.size() != 0) ? sb[0] : 8'h00;
            end
        end else begin
            t       = cyc - mon_start;
            bit_idx = t / CPB;
            if (bit_idx == 0)      exp_bit = 1'b0;
            else if (bit_idx == 9) exp_bit = 1'b1;
            else                   exp_bit = exp_byte[bit_idx-1];
            if (tx_o !== exp_bit) shape_errs++;
            if ((t % CPB == CPB / 2) && bit_idx >= 1 && bit_idx <= 8)
                rx_byte[bit_idx-1] = tx_o;
            if (t == FRAME - 1) begin
                check("frame_shape", shape_errs, 0);
                check("rx_byte", rx_byte, exp_byte);
                if (sb.size() != 0) void'(sb.pop_front());
                frames_done++;
                mon_active = 1'b0;
            end
        end
    end

    // Present a byte and hold it until the handshake edge; returns just after that edge.
    task automatic push_byte(input logic [7:0] b);
        int n;
        n       = 0;
        valid_i = 1'b1;
        data_i  = b;
        @(negedge clk);
        while (!ready_o && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) check("push_ready_timeout", ready_o, 1);
        sb.push_back(b);
        hs_cyc = cyc + 1;
        @(posedge clk);
        #1;
    endtask

    // Return at the first negedge where the cycle counter has reached c.
    task automatic wait_cyc(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frames_timeout", frames_done, target);
    endtask

    initial begin
        int n0;
        int n1;
        int frames_before;
        n_tests     = 0;
        n_fail      = 0;
        frames_done = 0;
        mon_active  = 1'b0;
        rst_ni      = 1'b0;
        valid_i     = 1'b0;
        data_i      = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tx", tx_o, 1);
        check("rst_ready", ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_count", count_o, 0);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Single byte 0x55: start latency, frame length, busy fall
        push_byte(8'h55);
        valid_i = 1'b0;
        n0 = hs_cyc;
        wait_cyc(n0);
        check("single_count_after_push", count_o, 1);
        check("single_tx_before_start", tx_o, 1);
        check("single_busy_before_start", busy_o, 0);
        wait_cyc(n0 + 1);
        check("single_tx_start", tx_o, 0);
        check("single_busy_rise", busy_o, 1);
        check("single_count_after_pop", count_o, 0);
        wait_cyc(n0 + FRAME);
        check("single_busy_last_stop", busy_o, 1);
        wait_cyc(n0 + FRAME + 1);
        check("single_busy_fall", busy_o, 0);
        check("single_tx_idle", tx_o, 1);
        wait_frames(1, 4 * FRAME);
        check("single_start_cyc", start_cycs[0], n0 + 1);

        // Back-to-back 0xA3, 0x0F
        @(posedge clk);
        #1;
        push_byte(8'hA3);
        n1 = hs_cyc;
        push_byte(8'h0F);
        valid_i = 1'b0;
        wait_cyc(n1 + 1);
        check("b2b_count_push_pop", count_o, 1);
        wait_cyc(n1 + 2 * FRAME);
        check("b2b_busy_last_stop", busy_o, 1);
        wait_cyc(n1 + 2 * FRAME + 1);
        check("b2b_busy_fall", busy_o, 0);
        wait_frames(3, 4 * FRAME);
        check("b2b_start1", start_cycs[1], n1 + 1);
        check("b2b_no_gap", start_cycs[2] - start_cycs[1], FRAME);

        // Full FIFO with valid held high: 0x01..0x06, last one waits for a pop
        @(posedge clk);
        #1;
        push_byte(8'h01);
        n0 = hs_cyc;
        for (int i = 2; i <= 5; i++) push_byte(8'(i));
        data_i = 8'h06;
        @(negedge clk);
        check("full_count", count_o, 4);
        check("full_ready_low", ready_o, 0);
        push_byte(8'h06);
        valid_i = 1'b0;
        check("full_accept_cyc", hs_cyc, n0 + 2 + FRAME);
        wait_frames(9, 8 * FRAME);
        check("full_order_gapless", start_cycs[8] - start_cycs[3], 5 * FRAME);

        // Reset during bit 4 of 0xFF with 0x11 still queued
        @(posedge clk);
        #1;
        frames_before = frames_done;
        push_byte(8'hFF);
        n0 = hs_cyc;
        push_byte(8'h11);
        valid_i = 1'b0;
        wait_cyc(n0 + 1 + 5 * CPB + CPB / 2);
        check("pre_reset_count", count_o, 1);
        check("pre_reset_busy", busy_o, 1);
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        sb.delete();
        #1;
        check("midrst_tx", tx_o, 1);
        check("midrst_count", count_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_ready", ready_o, 1);
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        push_byte(8'h3C);
        valid_i = 1'b0;
        wait_frames(frames_before + 1, 4 * FRAME);
        repeat (2 * FRAME) @(negedge clk);
        check("post_rst_frames", frames_done, frames_before + 1);
        check("post_rst_tx_idle", tx_o, 1);
        check("post_rst_busy", busy_o, 0);

        // Loopback-style decode of edge patterns
        @(posedge clk);
        #1;
        frames_before = frames_done;
        push_byte(8'h00);
        push_byte(8'hFF);
        push_byte(8'h80);
        valid_i = 1'b0;
        wait_frames(frames_before + 3, 6 * FRAME);

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_uart_tx_buffered
